// File: rtl/gcd_pkg.sv
// Shared types for the GCD requester: FSM state encoding, default widths and the response record.
package gcd_pkg;

  localparam int GCD_WIDTH = 16;
  localparam int GCD_TAG_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } gcd_req_state_e;

  // Response record at the default widths, for consumers built on the default configuration
  typedef struct packed {
    logic [GCD_WIDTH-1:0] result;
    logic [GCD_TAG_W-1:0] tag;
    logic                 timeout;
  } gcd_rsp_t;

endpackage

// File: rtl/gcd_req_timer.sv
// Watchdog counter for an outstanding GCD job; expire is combinational on the count.
// Zero latency from count to expire; no flow control, it holds at the last count once expired.
module gcd_req_timer #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expire) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = (cnt == LAST);

endmodule

// File: rtl/gcd_requester.sv
// Issues one GCD job at a time to a start/done responder; zero pairs answered locally, watchdog abort.
// Accept->start 1 cycle, done->rsp 1 cycle; req_ready low while a job or an unaccepted response is held.
module gcd_requester
  import gcd_pkg::*;
#(
  parameter int WIDTH       = GCD_WIDTH,
  parameter int TAG_W       = GCD_TAG_W,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             gcd_start,
  output logic [WIDTH-1:0] gcd_a,
  output logic [WIDTH-1:0] gcd_b,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_timeout,
  output logic [CNT_W-1:0] jobs_done,
  output logic [CNT_W-1:0] jobs_tmo
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [TAG_W-1:0] tag;
    logic             timeout;
  } rsp_t;

  gcd_req_state_e   state, state_nxt;
  rsp_t             rsp_q;
  logic [TAG_W-1:0] tag_cnt;
  logic             zero_pair, accept, wait_done, wait_tmo, rsp_fire;
  logic             tmr_clear, tmr_en, tmr_expire;

  gcd_req_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (tmr_clear),
    .enable(tmr_en),
    .expire(tmr_expire)
  );

  assign zero_pair = (req_a == '0) || (req_b == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    gcd_start = 1'b0;
    rsp_valid = 1'b0;
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = zero_pair ? RESP : ISSUE;
      end
      ISSUE: begin
        gcd_start = 1'b1;
        tmr_clear = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        // done wins over expiry when both land in the same cycle
        if (gcd_done || tmr_expire) state_nxt = RESP;
        else                        tmr_en    = 1'b1;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept    = req_valid && req_ready;
  assign wait_done = (state == WAIT) && gcd_done;
  assign wait_tmo  = (state == WAIT) && !gcd_done && tmr_expire;
  assign rsp_fire  = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcd_a     <= '0;
      gcd_b     <= '0;
      tag_cnt   <= '0;
      rsp_q     <= '0;
      jobs_done <= '0;
      jobs_tmo  <= '0;
    end else begin
      if (accept) begin
        gcd_a     <= req_a;
        gcd_b     <= req_b;
        rsp_q.tag <= tag_cnt;
        tag_cnt   <= tag_cnt + 1'b1;
        if (zero_pair) begin
          // gcd(x,0)=x and gcd(0,0)=0, so the OR is the answer
          rsp_q.result  <= req_a | req_b;
          rsp_q.timeout <= 1'b0;
        end
      end
      if (wait_done) begin
        rsp_q.result  <= gcd_result;
        rsp_q.timeout <= 1'b0;
      end
      if (wait_tmo) begin
        rsp_q.result  <= '0;
        rsp_q.timeout <= 1'b1;
      end
      if (rsp_fire) begin
        if (jobs_done != '1)                 jobs_done <= jobs_done + 1'b1;
        if (rsp_q.timeout && jobs_tmo != '1) jobs_tmo  <= jobs_tmo + 1'b1;
      end
    end
  end

  assign rsp_result  = rsp_q.result;
  assign rsp_tag     = rsp_q.tag;
  assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_gcd_requester.sv
// Self-checking bench for gcd_requester: behavioural GCD responder plus a mathematical reference model.
module tb_gcd_requester;

  localparam int WIDTH = 16;
  localparam int TAG_W = 4;
  localparam int TMO   = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid, req_ready;
  logic [WIDTH-1:0] req_a, req_b;
  logic             gcd_start;
  logic [WIDTH-1:0] gcd_a, gcd_b;
  logic             gcd_done;
  logic [WIDTH-1:0] gcd_result;
  logic             rsp_valid, rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_timeout;
  logic [CNT_W-1:0] jobs_done, jobs_tmo;

  always #5 clk = ~clk;

  gcd_requester #(
    .WIDTH(WIDTH), .TAG_W(TAG_W), .TIMEOUT_CYC(TMO), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .gcd_start(gcd_start), .gcd_a(gcd_a), .gcd_b(gcd_b),
    .gcd_done(gcd_done), .gcd_result(gcd_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout),
    .jobs_done(jobs_done), .jobs_tmo(jobs_tmo)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int start_cnt = 0;
  int resp_delay = 3;
  bit resp_never = 1'b0;
  int late_cnt = 0;
  int exp_tag = 0, cur_tag = 0, model_res = 0;
  int exp_done = 0, exp_tmo = 0;

  function automatic int ref_gcd(input int a, input int b);
    int x = a;
    int y = b;
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Responder: answers each start after resp_delay cycles, or never; can also inject stray done pulses
  initial begin
    int late_seen = 0;
    gcd_done   = 1'b0;
    gcd_result = '0;
    forever begin
      @(negedge clk);
      gcd_done = 1'b0;
      if (late_cnt != late_seen) begin
        late_seen  = late_cnt;
        gcd_done   = 1'b1;
        gcd_result = 16'hdead;
      end else if (gcd_start === 1'b1 && !resp_never) begin
        repeat (resp_delay) @(negedge clk);
        gcd_done   = 1'b1;
        gcd_result = WIDTH'(ref_gcd(int'(gcd_a), int'(gcd_b)));
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (gcd_start === 1'b1) start_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_req(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input string name);
    int n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s req_ready: got %b want 1", name, req_ready);
    end
    req_a = a; req_b = b; req_valid = 1'b1;
    cur_tag   = exp_tag;
    exp_tag   = (exp_tag + 1) % (1 << TAG_W);
    model_res = ref_gcd(int'(a), int'(b));
    @(negedge clk);
    req_valid = 1'b0;
    n_cmp++;
    if (a != 0 && b != 0) begin
      if (gcd_start !== 1'b1 || gcd_a !== a || gcd_b !== b) begin
        n_bad++;
        $display("FAIL %s issue: start=%b a=%0d b=%0d want start=1 a=%0d b=%0d",
                 name, gcd_start, gcd_a, gcd_b, a, b);
      end
    end else begin
      if (rsp_valid !== 1'b1 || gcd_start !== 1'b0) begin
        n_bad++;
        $display("FAIL %s zero_pair: rsp_valid=%b start=%b want 1/0", name, rsp_valid, gcd_start);
      end
    end
  endtask

  task automatic get_rsp(input bit exp_to, input int exp_lat, input int hold, input bit late,
                         input string name);
    int n = 0;
    int exp_res;
    exp_res = exp_to ? 0 : model_res;
    while (rsp_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (rsp_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL %s no response within %0d cycles", name, n);
      return;
    end
    if (exp_lat >= 0) begin
      n_cmp++;
      if (n != exp_lat) begin
        n_bad++;
        $display("FAIL %s latency: got %0d want %0d", name, n, exp_lat);
      end
    end
    n_cmp++;
    if (rsp_result !== exp_res[WIDTH-1:0] || int'(rsp_tag) != cur_tag || rsp_timeout !== exp_to) begin
      n_bad++;
      $display("FAIL %s rsp: result=%0d tag=%0d tmo=%b want %0d/%0d/%b",
               name, rsp_result, rsp_tag, rsp_timeout, exp_res, cur_tag, exp_to);
    end
    if (late) late_cnt++;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_a = WIDTH'($urandom) | 1;
      req_b = WIDTH'($urandom) | 1;
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_result !== exp_res[WIDTH-1:0] ||
          int'(rsp_tag) != cur_tag || rsp_timeout !== exp_to) begin
        n_bad++;
        $display("FAIL %s hold[%0d]: vld=%b rdy=%b res=%0d tag=%0d tmo=%b want 1/0/%0d/%0d/%b",
                 name, i, rsp_valid, req_ready, rsp_result, rsp_tag, rsp_timeout,
                 exp_res, cur_tag, exp_to);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_done++;
    if (exp_to) exp_tmo++;
    n_cmp++;
    if (rsp_valid !== 1'b0 || int'(jobs_done) != exp_done || int'(jobs_tmo) != exp_tmo) begin
      n_bad++;
      $display("FAIL %s counters: vld=%b done=%0d tmo=%0d want 0/%0d/%0d",
               name, rsp_valid, jobs_done, jobs_tmo, exp_done, exp_tmo);
    end
  endtask

  task automatic check_reset_values(input string name);
    n_cmp++;
    if (req_ready !== 1'b1 || gcd_start !== 1'b0 || gcd_a !== '0 || gcd_b !== '0 ||
        rsp_valid !== 1'b0 || rsp_result !== '0 || rsp_tag !== '0 || rsp_timeout !== 1'b0 ||
        jobs_done !== '0 || jobs_tmo !== '0) begin
      n_bad++;
      $display("FAIL %s: rdy=%b start=%b a=%0d b=%0d vld=%b res=%0d tag=%0d tmo=%b done=%0d jt=%0d want 1/0/0/0/0/0/0/0/0/0",
               name, req_ready, gcd_start, gcd_a, gcd_b, rsp_valid, rsp_result, rsp_tag,
               rsp_timeout, jobs_done, jobs_tmo);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    exp_tag = 0; exp_done = 0; exp_tmo = 0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int s0 = start_cnt;
    resp_delay = 5;
    send_req(16'd48, 16'd18, "basic");
    get_rsp(1'b0, 6, 0, 1'b0, "basic");
    n_cmp++;
    if (start_cnt - s0 != 1) begin
      n_bad++;
      $display("FAIL basic start_pulses: got %0d want 1", start_cnt - s0);
    end
  endtask

  task automatic test_zero();
    int s0 = start_cnt;
    send_req(16'd0, 16'd35, "zero_b35");
    get_rsp(1'b0, 0, 0, 1'b0, "zero_b35");
    send_req(16'd0, 16'd0, "zero_00");
    get_rsp(1'b0, 0, 0, 1'b0, "zero_00");
    send_req(16'd77, 16'd0, "zero_a77");
    get_rsp(1'b0, 0, 0, 1'b0, "zero_a77");
    n_cmp++;
    if (start_cnt != s0) begin
      n_bad++;
      $display("FAIL zero start_pulses: got %0d want 0", start_cnt - s0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      int g = $urandom_range(1, 50);
      logic [WIDTH-1:0] a = WIDTH'(g * $urandom_range(1, 300));
      logic [WIDTH-1:0] b = WIDTH'(g * $urandom_range(1, 300));
      if ($urandom_range(0, 5) == 0) a = '0;
      resp_delay = $urandom_range(1, 7);
      send_req(a, b, "random");
      get_rsp(1'b0, (a != 0 && b != 0) ? resp_delay + 1 : 0, $urandom_range(0, 2), 1'b0, "random");
    end
  endtask

  task automatic test_timeout();
    resp_never = 1'b1;
    send_req(16'd300, 16'd45, "timeout");
    get_rsp(1'b1, TMO + 1, 3, 1'b1, "timeout");
    late_cnt++;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL late_done: vld=%b rdy=%b want 0/1", rsp_valid, req_ready);
    end
    resp_never = 1'b0;
    resp_delay = 2;
    send_req(16'd21, 16'd14, "after_tmo");
    get_rsp(1'b0, 3, 0, 1'b0, "after_tmo");
  endtask

  task automatic test_hold();
    resp_delay = 2;
    send_req(16'd1071, 16'd462, "hold");
    get_rsp(1'b0, 3, 10, 1'b0, "hold");
  endtask

  task automatic test_midreset();
    resp_never = 1'b1;
    send_req(16'd100, 16'd75, "midreset");
    repeat (3) @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b0 || jobs_done === '0) begin
      n_bad++;
      $display("FAIL midreset pre: rdy=%b done=%0d want 0/nonzero", req_ready, jobs_done);
    end
    #2 rst_n = 1'b0;
    #1 check_reset_values("midreset_async");
    exp_tag = 0; exp_done = 0; exp_tmo = 0;
    @(negedge clk);
    rst_n = 1'b1;
    resp_never = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL midreset spurious rsp at cycle %0d: vld=%b want 0", i, rsp_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 17; i++) begin
      send_req(16'd0, WIDTH'($urandom_range(0, 1000)), "b2b");
      get_rsp(1'b0, 0, 0, 1'b0, "b2b");
    end
    n_cmp++;
    if (jobs_done !== 16'd17) begin
      n_bad++;
      $display("FAIL b2b jobs_done: got %0d want 17", jobs_done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_random();
    test_timeout();
    test_hold();
    test_midreset();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
